// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared state enum and ring-pointer wrap helper for the MFCC front end
package mfcc_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, EMIT, REFILL} fob_state_t;
  function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] flen);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, flen}) ? 16'(s - {1'b0, flen}) : s[15:0];
  endfunction
endpackage

// File: rtl/stream_skid.sv
// stream_skid: one-entry output register plus one-entry skid for a valid/ready stream
module stream_skid #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         sk_valid;
  logic [W-1:0] sk_data;
  assign in_ready = !sk_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
      out_data  <= '0;
      sk_data   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= sk_valid || in_valid;
      out_data  <= sk_valid ? sk_data : (in_valid ? in_data : out_data);
      sk_valid  <= 1'b0;
    end else if (in_valid && in_ready) begin
      sk_valid <= 1'b1;
      sk_data  <= in_data;
    end
  end
endmodule

// File: rtl/frame_overlap_buffer.sv
// frame_overlap_buffer: runtime-sized overlapping frame ring; FRAME_BUF_REPLAY_EN adds frame replay
module frame_overlap_buffer
  import mfcc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_FRAME = 512,
  parameter int LW        = $clog2(MAX_FRAME + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LW-1:0]    cfg_frame_len_i,
  input  logic [LW-1:0]    cfg_hop_len_i,
  input  logic             cfg_load_i,
  input  logic             flush_i,
  input  logic             replay_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_sof_o,
  output logic             m_eof_o,
  output logic [15:0]      frame_count_o,
  output logic             cfg_err_o,
  output logic             busy_o
);
  localparam int AW = $clog2(MAX_FRAME);
  localparam logic [LW-1:0] MAXF = LW'(MAX_FRAME);
  fob_state_t       state, state_nx;
  logic [WIDTH-1:0] mem [MAX_FRAME];
  logic [LW-1:0]    flen, hop, wp, base, rd_idx, cnt, rd_addr;
  logic             cfg_ok, s_acc, acc_last, issue, sk_ready, eof_hs, replay;
  logic [WIDTH+1:0] sk_out;
  assign cfg_ok = cfg_frame_len_i >= LW'(2) && cfg_frame_len_i <= MAXF &&
                  cfg_hop_len_i != '0 && cfg_hop_len_i <= cfg_frame_len_i;
  assign s_ready_o = (state == PRIME || state == REFILL) && !flush_i;
  assign s_acc     = s_valid_i && s_ready_o;
  assign acc_last  = cnt == ((state == PRIME) ? flen : hop) - LW'(1);
  assign eof_hs    = m_valid_o && m_ready_i && m_eof_o && !flush_i;
  assign issue     = state == EMIT && rd_idx != flen && sk_ready;
  assign rd_addr   = LW'(wrap_add(16'(base), 16'(rd_idx), 16'(flen)));
  assign busy_o    = state != IDLE;
  assign {m_data_o, m_sof_o, m_eof_o} = sk_out;
`ifdef FRAME_BUF_REPLAY_EN
  assign replay = replay_i && state == EMIT && !eof_hs;
`else
  logic unused_replay;
  assign unused_replay = replay_i;
  assign replay = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:          if (cfg_load_i && cfg_ok) state_nx = PRIME;
      PRIME, REFILL: if (s_acc && acc_last) state_nx = EMIT;
      EMIT:          if (eof_hs) state_nx = REFILL;
      default:       state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (s_acc) mem[wp[AW-1:0]] <= s_data_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flen          <= '0;
      hop           <= '0;
      wp            <= '0;
      base          <= '0;
      rd_idx        <= '0;
      cnt           <= '0;
      frame_count_o <= '0;
      cfg_err_o     <= 1'b0;
    end else begin
      if (state == IDLE && cfg_load_i && !flush_i) begin
        cfg_err_o <= !cfg_ok;
        if (cfg_ok) begin
          flen          <= cfg_frame_len_i;
          hop           <= cfg_hop_len_i;
          wp            <= '0;
          base          <= '0;
          cnt           <= '0;
          frame_count_o <= '0;
        end
      end
      if (s_acc) begin
        wp  <= LW'(wrap_add(16'(wp), 16'd1, 16'(flen)));
        cnt <= acc_last ? '0 : cnt + LW'(1);
        if (acc_last) rd_idx <= '0;
      end
      if (issue) rd_idx <= rd_idx + LW'(1);
      if (replay) rd_idx <= '0;
      if (eof_hs) begin
        frame_count_o <= frame_count_o + 16'd1;
        base          <= LW'(wrap_add(16'(base), 16'(hop), 16'(flen)));
      end
    end
  end
  // Sample and frame markers travel together so a stall freezes all three.
  stream_skid #(.W(WIDTH + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i || replay),
    .in_valid  (issue),
    .in_ready  (sk_ready),
    .in_data   ({mem[rd_addr[AW-1:0]], rd_idx == '0, rd_idx == flen - LW'(1)}),
    .out_valid (m_valid_o),
    .out_ready (m_ready_i),
    .out_data  (sk_out)
  );
endmodule

// File: tb/tb_frame_overlap_buffer.sv
// tb_frame_overlap_buffer: randomized directed bench against a sample-history frame model
module tb_frame_overlap_buffer;
  localparam int LW = 10;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cfg_frame_len_i = '0;
  logic [LW-1:0] cfg_hop_len_i = '0;
  logic          cfg_load_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          replay_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [15:0]   s_data_i = '0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [15:0]   m_data_o;
  logic          m_sof_o, m_eof_o;
  logic [15:0]   frame_count_o;
  logic          cfg_err_o, busy_o;
  int            n_cmp = 0;
  int            n_err = 0;

  frame_overlap_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_frame_len_i (cfg_frame_len_i),
    .cfg_hop_len_i   (cfg_hop_len_i),
    .cfg_load_i      (cfg_load_i),
    .flush_i         (flush_i),
    .replay_i        (replay_i),
    .s_valid_i       (s_valid_i),
    .s_ready_o       (s_ready_o),
    .s_data_i        (s_data_i),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .m_data_o        (m_data_o),
    .m_sof_o         (m_sof_o),
    .m_eof_o         (m_eof_o),
    .frame_count_o   (frame_count_o),
    .cfg_err_o       (cfg_err_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_s_ready", 32'(s_ready_o), 0);
    chk("rst_m_valid", 32'(m_valid_o), 0);
    chk("rst_sof", 32'(m_sof_o), 0);
    chk("rst_eof", 32'(m_eof_o), 0);
    chk("rst_data", 32'(m_data_o), 0);
    chk("rst_frame_count", 32'(frame_count_o), 0);
    chk("rst_cfg_err", 32'(cfg_err_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
  endtask

  // Flush back to IDLE (cfg survives), then load a new cfg.
  task automatic load(input int fl, input int hp, input bit err);
    @(negedge clk);
    flush_i = 1'b1; s_valid_i = 1'b0; replay_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; cfg_frame_len_i = LW'(fl); cfg_hop_len_i = LW'(hop_fix(hp)); cfg_load_i = 1'b1;
    @(negedge clk);
    cfg_load_i = 1'b0;
    #1;
    chk("cfg_err", 32'(cfg_err_o), 32'(err));
    chk("busy_after_load", 32'(busy_o), 32'(!err));
  endtask

  function automatic int hop_fix(input int hp);
    return hp;
  endfunction

  // Frame k of the model is samples k*hop .. k*hop+flen-1 of the accepted-input history.
  task automatic run(input int fl, input int hp, input int nf, input int rdy_pct, input int vld_pct,
                     input bit seq, input int rp_at, input bit nobub);
    logic [15:0] hist[$];
    logic [15:0] d = '0;
    logic [15:0] e;
    logic [17:0] held = '0;
    int fidx = 0, oidx = 0, cyc = 0, prime_cyc = -1, acc = 0, idx;
    bit stall = 1'b0, rp_done = 1'b0, seen_v = 1'b0;
    while (fidx < nf && cyc < 20000) begin
      @(negedge clk);
      s_valid_i = $urandom_range(99) < vld_pct;
      s_data_i  = seq ? d : 16'($urandom);
      m_ready_i = $urandom_range(99) < rdy_pct;
      replay_i  = 1'b0;
      if (rp_at >= 0 && !rp_done && oidx == rp_at) begin
        replay_i = 1'b1; m_ready_i = 1'b0;
      end
      #1;
      if (stall) begin
        chk("stall_valid", 32'(m_valid_o), 1);
        chk("stall_hold", 32'({m_data_o, m_sof_o, m_eof_o}), 32'(held));
      end
      if (!seen_v && m_valid_o) begin
        seen_v = 1'b1;
        chk("first_valid_latency", cyc - prime_cyc, 2);
      end
      if (nobub && oidx != 0) chk("no_bubble", 32'(m_valid_o), 1);
      if (s_valid_i && s_ready_o) begin
        hist.push_back(s_data_i);
        acc++; d++;
        if (acc == fl) prime_cyc = cyc;
      end
      if (m_valid_o && m_ready_i) begin
        idx = fidx * hp + oidx;
        e = (idx < hist.size()) ? hist[idx] : 'x;
        chk("data", 32'(m_data_o), 32'(e));
        chk("sof", 32'(m_sof_o), 32'(oidx == 0));
        chk("eof", 32'(m_eof_o), 32'(oidx == fl - 1));
        if (oidx == fl - 1) begin fidx++; oidx = 0; end
        else oidx++;
      end
      stall = m_valid_o && !m_ready_i;
      held  = {m_data_o, m_sof_o, m_eof_o};
      if (replay_i) begin rp_done = 1'b1; oidx = 0; stall = 1'b0; end
      cyc++;
    end
    chk("frames_done", fidx, nf);
    @(negedge clk);
    s_valid_i = 1'b0; replay_i = 1'b0;
    #1;
    chk("frame_count", 32'(frame_count_o), nf);
  endtask

  initial begin
    int n, cyc;
    repeat (3) @(negedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    load(1, 1, 1);
    load(513, 513, 1);
    load(4, 0, 1);
    load(8, 3, 0);
    run(8, 3, 4, 100, 100, 1, -1, 1);
    load(4, 2, 0);
    run(4, 2, 8, 50, 70, 0, -1, 0);
    load(5, 4, 0);
    run(5, 4, 6, 70, 80, 0, -1, 0);
    load(512, 512, 0);
    run(512, 512, 2, 100, 100, 0, -1, 1);
    load(8, 3, 0);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 200) begin
      @(negedge clk);
      s_valid_i = 1'b1; s_data_i = 16'($urandom); m_ready_i = 1'b1;
      #1;
      if (m_valid_o && m_ready_i) n++;
      cyc++;
    end
    chk("flush_reach", n, 2);
    @(negedge clk);
    flush_i = 1'b1; s_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_m_valid", 32'(m_valid_o), 0);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_s_ready", 32'(s_ready_o), 0);
    load(4, 4, 0);
    run(4, 4, 2, 80, 80, 0, -1, 0);
    load(6, 2, 0);
    repeat (3) begin
      @(negedge clk);
      s_valid_i = 1'b1; s_data_i = 16'($urandom);
    end
    @(negedge clk);
    s_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    cfg_frame_len_i = LW'(1); cfg_load_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    cfg_load_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_beats_load_err", 32'(cfg_err_o), 0);
    chk("flush_beats_load_busy", 32'(busy_o), 0);
    load(6, 2, 0);
    run(6, 2, 2, 60, 60, 0, -1, 0);
`ifdef FRAME_BUF_REPLAY_EN
    load(6, 2, 0);
    run(6, 2, 1, 100, 100, 0, 3, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_overlap_buffer.md
# frame_overlap_buffer

Runtime-configurable overlapping frame buffer for the MFCC front end, sitting between the sample FIFO and the windowing/FFT stages. It assembles `frame_len` samples into a frame, emits it on a valid/ready stream with start/end markers, then ingests `hop_len` new samples and emits the next overlapped frame. It generalises the fixed-size, fixed-hop window buffer: frame and hop lengths are chosen at run time up to a compile-time maximum, and both sides use full valid/ready handshakes with output backpressure.

## Interface
- `WIDTH`, 16, sample width in bits
- `MAX_FRAME`, 512, ring depth in samples; the largest legal `frame_len`
- `LW`, `$clog2(MAX_FRAME+1)`, width of the length fields (derived; do not override)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `cfg_frame_len_i`  in  LW  frame length; legal range 2..MAX_FRAME
- `cfg_hop_len_i`  in  LW  hop length; legal range 1..frame_len
- `cfg_load_i`  in  1  latch cfg and start priming; honoured only in IDLE
- `flush_i`  in  1  abort the current frame and return to IDLE; the latched cfg is kept
- `replay_i`  in  1  restart emission of the current frame (macro-gated)
- `s_valid_i`  in  1  input sample valid
- `s_ready_o`  out  1  input sample accepted when both valid and ready are high
- `s_data_i`  in  WIDTH  input sample
- `m_valid_o`  out  1  output sample valid
- `m_ready_i`  in  1  downstream ready
- `m_data_o`  out  WIDTH  output sample
- `m_sof_o`, `m_eof_o`  out  1  first / last sample of a frame, qualified by `m_valid_o`
- `frame_count_o`  out  16  frames fully emitted since cfg load; wraps at 16 bits
- `cfg_err_o`  out  1  sticky; the last `cfg_load_i` carried an illegal cfg
- `busy_o`  out  1  state is not IDLE

## Operation
- The ring buffer `mem[MAX_FRAME]` is used as a ring of length `flen` (the latched `frame_len`). The write pointer `wp` and the frame base `base` both wrap at `flen` by compare-and-subtract. `%` is not used.
- States: IDLE, PRIME, EMIT, REFILL.
- IDLE: on `cfg_load_i`, check the config.
  - Illegal config: set `cfg_err_o` and stay in IDLE.
  - Legal config: latch `flen`/`hop`, clear `cfg_err_o`, `wp`, `base`, `frame_count_o`, and go to PRIME.
- PRIME: `s_ready_o`=1. Each accepted sample writes `mem[wp]` and advances `wp`. After `flen` accepts, go to EMIT with `rd_idx`=0.
- EMIT: read `mem[(base+rd_idx) wrap flen]`.
  - `m_sof_o` is high when `rd_idx`=0; `m_eof_o` is high when `rd_idx`=flen-1.
  - On the eof handshake: `frame_count_o`++, `base` += `hop` (wrapped), go to REFILL.
- REFILL: `s_ready_o`=1. After `hop` accepts, go to EMIT. The next frame reuses `flen-hop` old samples.
- With `hop==flen` there is no overlap. With `hop`=1 each frame shifts by one sample.
- `flush_i` takes priority over all other events. From any state it goes to IDLE next cycle, drops `m_valid_o`, and keeps the pipeline empty.
- Simultaneous `cfg_load_i` and `flush_i` in IDLE: flush wins and the load is ignored.
- `s_ready_o` is 0 in IDLE and EMIT. Input and output never overlap, so emission order is deterministic.

## Timing
- Reset values: `s_ready_o`=0, `m_valid_o`=0, `m_sof_o`=0, `m_eof_o`=0, `m_data_o`=0, `frame_count_o`=0, `cfg_err_o`=0, `busy_o`=0. State is IDLE.
- `rst_n` asserted mid-frame aborts immediately. Memory contents are not cleared, and no stale sample is emitted afterwards.
- Output is a registered synchronous read with 1-cycle latency, behind a one-entry output register plus a one-entry skid.
  - `m_valid_o` rises 1 cycle after entering EMIT.
  - With `m_ready_i` held high, one sample per cycle is emitted with no bubbles.
  - While `m_valid_o` && !`m_ready_i`, `m_data_o`, `m_sof_o` and `m_eof_o` stay stable.
- A write to `mem[wp]` in REFILL never targets a slot still pending in the output skid, because EMIT has fully drained before REFILL is entered.
- Bubbles on `s_valid_i` only stall PRIME/REFILL. No samples are lost.
- `cfg_err_o` updates 1 cycle after `cfg_load_i`.

## Configuration
- Macro: `FRAME_BUF_REPLAY_EN`.
- Defined: `replay_i` pulsed in EMIT discards output in flight and restarts at `rd_idx`=0.
  - `m_sof_o` is reasserted.
  - `frame_count_o` is not incremented.
  - Replay on the eof handshake cycle is ignored.
- Undefined: `replay_i` is ignored and its logic is not synthesised.

## Structure
- Package `mfcc_pkg`: the `fob_state_t` enum (IDLE, PRIME, EMIT, REFILL) and a `wrap_add` function (a+b, subtracting `flen` when the sum is ≥ `flen`).
- Sub-module `stream_skid` (WIDTH+2 bits: data, sof, eof): a one-entry output register plus skid, reusable elsewhere in the pipeline.

## Test plan
- Basic overlap: flen=8, hop=3, inputs 0..16, `m_ready_i`=1.
  - Frames: 0..7, then 3..10, then 6..13, then 9..16.
  - sof/eof on the first/last sample of each frame; `frame_count_o`=4.
- Backpressure: flen=4, hop=2, `m_ready_i` toggling randomly.
  - Output sequence identical to the no-stall case.
  - Data stable while stalled; no duplicated or dropped samples.
- Config checks:
  - `cfg_load_i` with flen=1 → `cfg_err_o`=1, state stays IDLE.
  - flen=513 with MAX_FRAME=512 → `cfg_err_o`=1.
  - Then flen=512, hop=512 → `cfg_err_o`=0, and non-overlapping frames of 512 samples.
- Wrap: flen=5, hop=4, 6 frames.
  - `base` sequence 0,4,3,2,1,0.
  - Each frame equals the last 5 inputs accepted.
- Flush and reset mid-frame:
  - `flush_i` at `rd_idx`=2 → `m_valid_o`=0 next cycle, IDLE.
  - A new `cfg_load_i` restarts priming from an empty ring.
  - `rst_n` low mid-PRIME → all outputs at reset values.
- Replay (macro defined): flen=6, `replay_i` at `rd_idx`=3.
  - Emission restarts at sample 0 with sof.
  - `frame_count_o` increments once for that frame.
